// File: rtl/rom_download_sink.sv
// ioctl download sink: packs HPS bytes little-endian into 16-bit SDRAM word
// writes, back-pressures the HPS while a word is outstanding, flags ROM ready.
module rom_download_sink #(
  parameter int ADDR_W    = 23,
  parameter int ROM_INDEX = 0
) (
  input  logic              i_EMU_MCLK,
  input  logic              i_EMU_RST_n,
  input  logic              i_IOCTL_DOWNLOAD,
  input  logic [15:0]       i_IOCTL_INDEX,
  input  logic [26:0]       i_IOCTL_ADDR,
  input  logic [7:0]        i_IOCTL_DATA,
  input  logic              i_IOCTL_WR,
  output logic              o_IOCTL_WAIT,
  output logic              o_SDRAM_WR_REQ,
  output logic [ADDR_W-1:0] o_SDRAM_WR_ADDR,
  output logic [15:0]       o_SDRAM_WR_DATA,
  output logic [1:0]        o_SDRAM_WR_BE,
  input  logic              i_SDRAM_WR_ACK,
  output logic              o_ROM_READY,
  output logic              o_OVERRUN,
  output logic [ADDR_W-1:0] o_WORD_CNT
);

  // state    | meaning
  // ST_IDLE  | no request outstanding, accepting bytes
  // ST_WRITE | full/odd-half word request outstanding, waiting for ACK
  // ST_FLUSH | trailing even byte of an odd-length image outstanding
  // ST_READY | image committed, ROM_READY held
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_FLUSH, ST_READY} state_t;

  state_t            state_q, state_d, st_cur;
  logic              sel, sel_q, start, stop, wr_even, wr_odd;
  logic [ADDR_W-1:0] byte_waddr;
  logic [7:0]        lo_q, lo_d;
  logic              lo_vld_q, lo_vld_d, lo_vld_cur;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              req_q, req_d, wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [1:0]        be_q, be_d;
  logic              ready_q, ready_d, ovr_q, ovr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              endp_q, endp_d, endp_cur;
  logic              unused_addr_hi;

  assign sel            = i_IOCTL_DOWNLOAD && (i_IOCTL_INDEX == 16'(ROM_INDEX));
  assign start          = sel && !sel_q;
  assign stop           = !sel && sel_q;
  assign wr_even        = i_IOCTL_WR && sel && !i_IOCTL_ADDR[0];
  assign wr_odd         = i_IOCTL_WR && sel && i_IOCTL_ADDR[0];
  assign byte_waddr     = i_IOCTL_ADDR[ADDR_W:1];
  assign unused_addr_hi = &{1'b0, i_IOCTL_ADDR[26:ADDR_W+1]};

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= 1'b0;
      lo_q     <= '0;
      lo_vld_q <= 1'b0;
      waddr_q  <= '0;
      req_q    <= 1'b0;
      wait_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      be_q     <= '0;
      ready_q  <= 1'b0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
      endp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel;
      lo_q     <= lo_d;
      lo_vld_q <= lo_vld_d;
      waddr_q  <= waddr_d;
      req_q    <= req_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      be_q     <= be_d;
      ready_q  <= ready_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
      endp_q   <= endp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    lo_vld_d   = lo_vld_q;
    waddr_d    = waddr_q;
    req_d      = req_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    data_d     = data_q;
    be_d       = be_q;
    ready_d    = ready_q;
    ovr_d      = ovr_q;
    cnt_d      = cnt_q;
    endp_d     = endp_q;
    st_cur     = state_q;
    lo_vld_cur = lo_vld_q;
    endp_cur   = endp_q;

    // A download start wipes the session; the case below then runs as if idle
    // so a strobe landing on the start cycle is not lost.
    if (start) begin
      st_cur     = ST_IDLE;
      lo_vld_cur = 1'b0;
      endp_cur   = 1'b0;
      state_d    = ST_IDLE;
      lo_vld_d   = 1'b0;
      endp_d     = 1'b0;
      ready_d    = 1'b0;
      ovr_d      = 1'b0;
      cnt_d      = '0;
      req_d      = 1'b0;
      wait_d     = 1'b0;
    end

    case (st_cur)
      ST_IDLE: begin
        if (wr_odd) begin
          req_d    = 1'b1;
          wait_d   = 1'b1;
          addr_d   = byte_waddr;
          data_d   = {i_IOCTL_DATA, lo_q};
          be_d     = lo_vld_cur ? 2'b11 : 2'b10;
          lo_vld_d = 1'b0;
          state_d  = ST_WRITE;
        end else if (stop || endp_cur) begin
          endp_d = 1'b0;
          if (lo_vld_cur) begin
            req_d   = 1'b1;
            wait_d  = 1'b1;
            addr_d  = waddr_q;
            data_d  = {8'h00, lo_q};
            be_d    = 2'b01;
            state_d = ST_FLUSH;
          end else begin
            ready_d = 1'b1;
            state_d = ST_READY;
          end
        end
      end
      ST_WRITE: begin
        // download end while a word is in flight is finished from IDLE
        if (stop) endp_d = 1'b1;
        if (wr_odd) ovr_d = 1'b1;
        if (i_SDRAM_WR_ACK) begin
          req_d   = 1'b0;
          wait_d  = 1'b0;
          cnt_d   = cnt_q + ADDR_W'(1);
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (wr_odd) ovr_d = 1'b1;
        if (i_SDRAM_WR_ACK) begin
          req_d    = 1'b0;
          wait_d   = 1'b0;
          cnt_d    = cnt_q + ADDR_W'(1);
          lo_vld_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = ST_READY;
        end
      end
      ST_READY: ;
      default: state_d = ST_IDLE;
    endcase

    if (wr_even) begin
      lo_d     = i_IOCTL_DATA;
      lo_vld_d = 1'b1;
      waddr_d  = byte_waddr;
    end
  end

  assign o_IOCTL_WAIT    = wait_q;
  assign o_SDRAM_WR_REQ  = req_q;
  assign o_SDRAM_WR_ADDR = addr_q;
  assign o_SDRAM_WR_DATA = data_q;
  assign o_SDRAM_WR_BE   = be_q;
  assign o_ROM_READY     = ready_q;
  assign o_OVERRUN       = ovr_q;
  assign o_WORD_CNT      = cnt_q;

endmodule

// File: tb/tb_rom_download_sink.sv
// Bench for rom_download_sink: directed scenarios plus random images checked
// against a word-level model of the expected SDRAM write stream.
module tb_rom_download_sink;
  localparam int ADDR_W = 23;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              i_IOCTL_DOWNLOAD = 1'b0;
  logic [15:0]       i_IOCTL_INDEX = '0;
  logic [26:0]       i_IOCTL_ADDR = '0;
  logic [7:0]        i_IOCTL_DATA = '0;
  logic              i_IOCTL_WR = 1'b0;
  logic              o_IOCTL_WAIT;
  logic              o_SDRAM_WR_REQ;
  logic [ADDR_W-1:0] o_SDRAM_WR_ADDR;
  logic [15:0]       o_SDRAM_WR_DATA;
  logic [1:0]        o_SDRAM_WR_BE;
  logic              i_SDRAM_WR_ACK;
  logic              o_ROM_READY;
  logic              o_OVERRUN;
  logic [ADDR_W-1:0] o_WORD_CNT;

  rom_download_sink #(.ADDR_W(ADDR_W), .ROM_INDEX(0)) dut (
    .i_EMU_MCLK      (clk),
    .i_EMU_RST_n     (rst_n),
    .i_IOCTL_DOWNLOAD(i_IOCTL_DOWNLOAD),
    .i_IOCTL_INDEX   (i_IOCTL_INDEX),
    .i_IOCTL_ADDR    (i_IOCTL_ADDR),
    .i_IOCTL_DATA    (i_IOCTL_DATA),
    .i_IOCTL_WR      (i_IOCTL_WR),
    .o_IOCTL_WAIT    (o_IOCTL_WAIT),
    .o_SDRAM_WR_REQ  (o_SDRAM_WR_REQ),
    .o_SDRAM_WR_ADDR (o_SDRAM_WR_ADDR),
    .o_SDRAM_WR_DATA (o_SDRAM_WR_DATA),
    .o_SDRAM_WR_BE   (o_SDRAM_WR_BE),
    .i_SDRAM_WR_ACK  (i_SDRAM_WR_ACK),
    .o_ROM_READY     (o_ROM_READY),
    .o_OVERRUN       (o_OVERRUN),
    .o_WORD_CNT      (o_WORD_CNT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        be;
    logic              dl;
  } wr_t;
  typedef logic [7:0] img_t[$];

  int  n_vec = 0;
  int  n_err = 0;
  wr_t got_q[$];
  int  ack_dly = 2;
  bit  ack_en = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // SDRAM side: acknowledge each request ack_dly cycles after it is seen
  initial begin
    int cnt;
    cnt = 0;
    i_SDRAM_WR_ACK = 1'b0;
    forever begin
      @(negedge clk);
      if (i_SDRAM_WR_ACK) begin
        i_SDRAM_WR_ACK = 1'b0;
      end else if (o_SDRAM_WR_REQ && ack_en) begin
        if (cnt >= ack_dly) begin
          i_SDRAM_WR_ACK = 1'b1;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // Request monitor: capture each new request, enforce stability and WAIT/READY relations
  initial begin
    logic prev_req;
    wr_t  cur;
    prev_req = 1'b0;
    cur = '{addr: '0, data: '0, be: '0, dl: 1'b0};
    forever begin
      @(negedge clk);
      check_eq("wait_tracks_req", 32'(o_IOCTL_WAIT), 32'(o_SDRAM_WR_REQ));
      if (o_SDRAM_WR_REQ) begin
        check_eq("ready_low_during_req", 32'(o_ROM_READY), 32'd0);
        if (!prev_req) begin
          cur = '{addr: o_SDRAM_WR_ADDR, data: o_SDRAM_WR_DATA, be: o_SDRAM_WR_BE,
                  dl: i_IOCTL_DOWNLOAD};
          got_q.push_back(cur);
        end else begin
          check_eq("req_addr_stable", 32'(o_SDRAM_WR_ADDR), 32'(cur.addr));
          check_eq("req_data_stable", 32'(o_SDRAM_WR_DATA), 32'(cur.data));
          check_eq("req_be_stable", 32'(o_SDRAM_WR_BE), 32'(cur.be));
        end
      end
      prev_req = o_SDRAM_WR_REQ;
    end
  end

  task automatic wait_no_wait();
    int t;
    t = 0;
    while (o_IOCTL_WAIT && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("wait_released", 32'(o_IOCTL_WAIT), 32'd0);
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!o_ROM_READY && t < 200) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
    wait_no_wait();
    i_IOCTL_WR   = 1'b1;
    i_IOCTL_ADDR = a;
    i_IOCTL_DATA = d;
    @(negedge clk);
    i_IOCTL_WR   = 1'b0;
  endtask

  task automatic begin_download(input logic [15:0] idx);
    @(negedge clk);
    i_IOCTL_INDEX    = idx;
    i_IOCTL_DOWNLOAD = 1'b1;
    @(negedge clk);
  endtask

  // Full download of an image at byte address base; checks the resulting write stream
  task automatic do_download(input logic [15:0] idx, input img_t img, input int base, input int dly);
    wr_t exp_q[$];
    int  n;
    bit  match;
    n = img.size();
    match = (idx == 16'd0);
    ack_dly = dly;
    got_q.delete();
    begin_download(idx);
    if (match) begin
      check_eq("start_ready_clr", 32'(o_ROM_READY), 32'd0);
      check_eq("start_cnt_clr", 32'(o_WORD_CNT), 32'd0);
      check_eq("start_ovr_clr", 32'(o_OVERRUN), 32'd0);
    end
    for (int i = 0; i < n; i++) send_byte(27'(base + i), img[i]);
    wait_no_wait();
    i_IOCTL_DOWNLOAD = 1'b0;
    if (match) wait_ready();
    else repeat (10) @(negedge clk);

    if (match) begin
      for (int k = 0; k < n / 2; k++)
        exp_q.push_back('{addr: ADDR_W'(base / 2 + k), data: {img[2*k+1], img[2*k]},
                          be: 2'b11, dl: 1'b1});
      if (n % 2 == 1)
        exp_q.push_back('{addr: ADDR_W'(base / 2 + n / 2), data: {8'h00, img[n-1]},
                          be: 2'b01, dl: 1'b0});
    end
    check_eq("write_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check_eq("wr_addr", 32'(got_q[k].addr), 32'(exp_q[k].addr));
      check_eq("wr_data", 32'(got_q[k].data), 32'(exp_q[k].data));
      check_eq("wr_be", 32'(got_q[k].be), 32'(exp_q[k].be));
      check_eq("wr_during_download", 32'(got_q[k].dl), 32'(exp_q[k].dl));
    end
    check_eq("word_cnt", 32'(o_WORD_CNT), 32'(exp_q.size()));
    check_eq("rom_ready", 32'(o_ROM_READY), 32'(match));
    check_eq("overrun_clear", 32'(o_OVERRUN), 32'd0);
  endtask

  initial begin
    img_t img;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req", 32'(o_SDRAM_WR_REQ), 32'd0);
    check_eq("rst_wait", 32'(o_IOCTL_WAIT), 32'd0);
    check_eq("rst_ready", 32'(o_ROM_READY), 32'd0);
    check_eq("rst_ovr", 32'(o_OVERRUN), 32'd0);
    check_eq("rst_cnt", 32'(o_WORD_CNT), 32'd0);
    check_eq("rst_data", 32'(o_SDRAM_WR_DATA), 32'd0);
    check_eq("rst_be", 32'(o_SDRAM_WR_BE), 32'd0);
    rst_n = 1'b1;

    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_download(16'd1, img, 0, 2);
    do_download(16'd0, img, 0, 2);
    img = '{8'hAA, 8'hBB, 8'hCC};
    do_download(16'd0, img, 0, 1);

    // overrun: odd byte forced in while the request is held unacknowledged
    got_q.delete();
    ack_dly = 0;
    begin_download(16'd0);
    check_eq("ovr_start_ready_clr", 32'(o_ROM_READY), 32'd0);
    ack_en = 1'b0;
    send_byte(27'd0, 8'h55);
    send_byte(27'd1, 8'h66);
    i_IOCTL_WR = 1'b1; i_IOCTL_ADDR = 27'd3; i_IOCTL_DATA = 8'h77;
    @(negedge clk);
    i_IOCTL_WR = 1'b0;
    check_eq("ovr_flag", 32'(o_OVERRUN), 32'd1);
    check_eq("ovr_req_held", 32'(o_SDRAM_WR_REQ), 32'd1);
    check_eq("ovr_data_held", 32'(o_SDRAM_WR_DATA), 32'h6655);
    check_eq("ovr_addr_held", 32'(o_SDRAM_WR_ADDR), 32'd0);
    check_eq("ovr_be_held", 32'(o_SDRAM_WR_BE), 32'd3);
    ack_en = 1'b1;
    wait_no_wait();
    i_IOCTL_DOWNLOAD = 1'b0;
    wait_ready();
    check_eq("ovr_ready", 32'(o_ROM_READY), 32'd1);
    check_eq("ovr_sticky", 32'(o_OVERRUN), 32'd1);
    check_eq("ovr_cnt", 32'(o_WORD_CNT), 32'd1);
    check_eq("ovr_writes", 32'(got_q.size()), 32'd1);

    for (int r = 0; r < 3; r++) begin
      img.delete();
      for (int i = 0; i < $urandom_range(1, 12); i++) img.push_back(8'($urandom));
      do_download(16'd0, img, 2 * int'($urandom_range(0, 1000)), int'($urandom_range(0, 4)));
    end

    // reset while a word is outstanding
    begin_download(16'd0);
    ack_en = 1'b0;
    send_byte(27'd0, 8'h12);
    send_byte(27'd1, 8'h34);
    check_eq("mid_write_req", 32'(o_SDRAM_WR_REQ), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_req", 32'(o_SDRAM_WR_REQ), 32'd0);
    check_eq("async_rst_wait", 32'(o_IOCTL_WAIT), 32'd0);
    check_eq("async_rst_ready", 32'(o_ROM_READY), 32'd0);
    check_eq("async_rst_cnt", 32'(o_WORD_CNT), 32'd0);
    i_IOCTL_DOWNLOAD = 1'b0;
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 4; r++) begin
      img.delete();
      for (int i = 0; i < $urandom_range(1, 12); i++) img.push_back(8'($urandom));
      do_download(16'd0, img, 2 * int'($urandom_range(0, 1000)), int'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rom_download_sink.md
Name: rom_download_sink

Overview:
- Receiving end of the HPS ioctl download stream.
- Accepts byte writes for one ioctl index and packs them little-endian into 16-bit words. Issues one SDRAM write request per word and back-pressures the HPS through ioctl_wait while a word is outstanding.
- Sits between hps_io and the SDRAM controller's write port in Psychic5_emu.
- Drives o_ROM_READY, which holds the game board in reset until the image is fully committed.

Parameters:
- ADDR_W, 23: SDRAM word-address width; word address = i_IOCTL_ADDR[ADDR_W:1].
- ROM_INDEX, 0: i_IOCTL_INDEX value that selects this sink; all other indices are ignored.

Ports:
- i_EMU_MCLK  in  1  system clock (60 MHz), all logic on rising edge.
- i_EMU_RST_n  in  1  asynchronous active-low reset.
- i_IOCTL_DOWNLOAD  in  1  download-in-progress level from hps_io.
- i_IOCTL_INDEX  in  16  download target index.
- i_IOCTL_ADDR  in  27  byte address of current byte.
- i_IOCTL_DATA  in  8  byte data.
- i_IOCTL_WR  in  1  one-cycle byte strobe.
- o_IOCTL_WAIT  out  1  back-pressure to hps_io.
- o_SDRAM_WR_REQ  out  1  write request level.
- o_SDRAM_WR_ADDR  out  ADDR_W  word address.
- o_SDRAM_WR_DATA  out  16  {odd byte, even byte}.
- o_SDRAM_WR_BE  out  2  byte enables, [0]=low byte.
- i_SDRAM_WR_ACK  in  1  one-cycle acceptance of current request.
- o_ROM_READY  out  1  image fully written.
- o_OVERRUN  out  1  sticky protocol-violation flag.
- o_WORD_CNT  out  ADDR_W  words committed this download.

Behaviour:
- Reset (async assert, sync deassert by the system): all outputs 0, state IDLE, low-byte latch 0, low-valid flag 0.
- sel = i_IOCTL_DOWNLOAD & (i_IOCTL_INDEX == ROM_INDEX). Strobes with sel=0 are ignored entirely.
- Download start, detected as the rising edge of sel (one-cycle registered compare):
  - clear o_ROM_READY, o_WORD_CNT, o_OVERRUN and the low-valid flag;
  - state→IDLE.
- Even byte (addr[0]=0) strobe: latch data into low byte, set low-valid, record word address. Accepted in any state; it does not disturb a pending request's output registers.
- Odd byte (addr[0]=1) strobe in IDLE:
  - next cycle o_SDRAM_WR_REQ=1, DATA={byte, low latch}, BE=2'b11 (2'b10 if low-valid=0), ADDR=addr[ADDR_W:1];
  - clear low-valid; state→WRITE.
- WRITE state:
  - REQ, ADDR, DATA, BE held stable; o_IOCTL_WAIT=1 (registered, asserted in the same cycle REQ rises).
  - On i_SDRAM_WR_ACK: REQ=0 and WAIT=0 next cycle, o_WORD_CNT+1, state→IDLE.
  - Latency from odd strobe to REQ: 1 cycle.
- Odd byte strobe while in WRITE or FLUSH: byte dropped, o_OVERRUN←1 (sticky until next download start), current request unaffected.
- Download end, detected as the falling edge of sel:
  - If low-valid=1 (odd-length image), state→FLUSH: REQ with DATA={8'h00, low latch}, BE=2'b01. On ACK, count+1, then READY.
  - If a WRITE is pending, FLUSH/READY is entered only after its ACK.
  - Otherwise state→READY.
- READY: o_ROM_READY=1 held until the next download start or reset. WAIT=0.
- ACK while REQ=0: ignored.
- ACK in the same cycle as a new odd strobe in WRITE: the ACK completes the old word; the strobe counts as overrun (the HPS must honour WAIT).
- Reset mid-WRITE: request dropped immediately, no partial state retained, o_ROM_READY=0.
- o_WORD_CNT wraps modulo 2^ADDR_W and never saturates.
- No other request is ever issued; at most one request outstanding.

Test Plan:
- Download idx0 bytes 0x11,0x22,0x33,0x44 at addr 0..3, ACK 3 cycles after each REQ:
  - writes (addr0, 0x2211, BE=11) and (addr1, 0x4433, BE=11);
  - WAIT high exactly while REQ high;
  - o_WORD_CNT=2; o_ROM_READY=1 after download falls.
- Odd-length image 0xAA,0xBB,0xCC: second write is (addr1, 0x00CC, BE=01), issued after download falls; READY only after its ACK.
- Download with index 1: no REQ, READY stays 0, WORD_CNT stays 0.
- Odd byte strobed while REQ pending and ACK withheld: o_OVERRUN=1, REQ/DATA unchanged; next download start clears OVERRUN.
- Assert i_EMU_RST_n=0 during WRITE: REQ, WAIT and READY go 0 asynchronously. After release, a fresh download completes normally.
- Second download after READY: READY drops on the rising edge of download; WORD_CNT restarts from 0.
